// File: rtl/adc_share_arbiter_pkg.sv
// Shared definitions for the ADC sharing arbiter: FSM encoding and default sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ADC = 2'd1,
    ST_GAP      = 2'd2
  } state_t;

  localparam int NREQ_DEF    = 4;
  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 64;
  localparam int GAP_DEF     = 2;

endpackage

// File: rtl/adc_share_arbiter_if.sv
// Client-side and ADC-side handshake bundle for the ADC sharing arbiter.
// Latency: n/a (wiring only).
// Backpressure: clients hold cli_req until their rdy/err pulse; ADC answers with adc_rdy.
interface adc_share_arbiter_if
  import adc_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            en;
  logic [NREQ-1:0] cli_req;
  logic [NREQ-1:0] cli_rdy;
  logic [NREQ-1:0] cli_err;
  logic [DW-1:0]   cli_dat;
  logic [IW-1:0]   gnt_id;
  logic            busy;
  logic            adc_req;
  logic            adc_rdy;
  logic [DW-1:0]   adc_dat;
  logic            err_sticky;
  logic            clr_err;

  // Arbiter side.
  modport slave (
    input  en, cli_req, adc_rdy, adc_dat, clr_err,
    output cli_rdy, cli_err, cli_dat, gnt_id, busy, adc_req, err_sticky
  );

  // Clients + ADC side.
  modport master (
    output en, cli_req, adc_rdy, adc_dat, clr_err,
    input  cli_rdy, cli_err, cli_dat, gnt_id, busy, adc_req, err_sticky
  );
endinterface

// File: rtl/adc_share_arbiter_rr_pick.sv
// Round-robin selector: first set request scanning last+1, last+2, ... (mod NREQ).
// Latency: combinational.
// Backpressure: none; o_vld low when no request is set.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [IW-1:0]   o_winner,
  output logic            o_vld
);

  // Scan from furthest to nearest so the nearest set bit after i_last wins.
  always_comb begin
    logic [NREQ-1:0] w_sh;
    int              w_idx;
    o_winner = i_last;
    o_vld    = 1'b0;
    w_sh     = '0;
    w_idx    = 0;
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = int'(i_last) + i;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      w_sh = i_req >> w_idx;
      if (w_sh[0]) begin
        o_winner = IW'(w_idx);
        o_vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_share_arbiter.sv
// Shares one ADC port among NREQ clients: round-robin grant, one conversion per grant, idle gap, timeout.
// Latency: grant 1 cycle after request in IDLE; data/err pulse 1 cycle after adc_rdy or timeout edge.
// Backpressure: en gates new grants only; clients wait (hold cli_req) while another conversion runs.
module adc_share_arbiter
  import adc_share_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int GAP     = GAP_DEF
) (
  input logic                 clk,
  input logic                 rst,
  adc_share_arbiter_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP - 1);

  state_t          r_state,   w_state_nxt;
  logic            r_adc_req, w_adc_req_nxt;
  logic            r_busy,    w_busy_nxt;
  logic [NREQ-1:0] r_cli_rdy, w_cli_rdy_nxt;
  logic [NREQ-1:0] r_cli_err, w_cli_err_nxt;
  logic [DW-1:0]   r_cli_dat, w_cli_dat_nxt;
  logic [IW-1:0]   r_gnt_id,  w_gnt_id_nxt;
  logic [IW-1:0]   r_last,    w_last_nxt;
  logic [TW-1:0]   r_tcnt,    w_tcnt_nxt;
  logic [GW-1:0]   r_gcnt,    w_gcnt_nxt;
  logic            r_err,     w_err_nxt;

  logic [IW-1:0]   w_pick;
  logic            w_pick_vld;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req    (bus.cli_req),
    .i_last   (r_last),
    .o_winner (w_pick),
    .o_vld    (w_pick_vld)
  );

  // Next-state and next-output decode; pulses default low every cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_adc_req_nxt = r_adc_req;
    w_busy_nxt    = r_busy;
    w_cli_rdy_nxt = '0;
    w_cli_err_nxt = '0;
    w_cli_dat_nxt = r_cli_dat;
    w_gnt_id_nxt  = r_gnt_id;
    w_last_nxt    = r_last;
    w_tcnt_nxt    = r_tcnt;
    w_gcnt_nxt    = r_gcnt;
    w_err_nxt     = bus.clr_err ? 1'b0 : r_err;
    case (r_state)
      ST_IDLE: begin
        if (bus.en && w_pick_vld) begin
          w_gnt_id_nxt  = w_pick;
          w_last_nxt    = w_pick;
          w_adc_req_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
          w_tcnt_nxt    = '0;
          w_state_nxt   = ST_WAIT_ADC;
        end
      end
      ST_WAIT_ADC: begin
        if (bus.adc_rdy) begin
          // Data beats a timeout landing on the same edge.
          w_cli_dat_nxt = bus.adc_dat;
          w_cli_rdy_nxt = NREQ'(1) << r_gnt_id;
          w_adc_req_nxt = 1'b0;
          w_gcnt_nxt    = '0;
          w_state_nxt   = ST_GAP;
        end else if (r_tcnt == TLAST) begin
          // Timeout set overrides a simultaneous clr_err.
          w_cli_err_nxt = NREQ'(1) << r_gnt_id;
          w_err_nxt     = 1'b1;
          w_adc_req_nxt = 1'b0;
          w_gcnt_nxt    = '0;
          w_state_nxt   = ST_GAP;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gcnt == GLAST) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_gcnt_nxt = r_gcnt + 1'b1;
        end
      end
      default: begin
        w_adc_req_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction with no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_adc_req <= 1'b0;
      r_busy    <= 1'b0;
      r_cli_rdy <= '0;
      r_cli_err <= '0;
      r_cli_dat <= '0;
      r_gnt_id  <= '0;
      r_last    <= IW'(NREQ - 1);
      r_tcnt    <= '0;
      r_gcnt    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_adc_req <= w_adc_req_nxt;
      r_busy    <= w_busy_nxt;
      r_cli_rdy <= w_cli_rdy_nxt;
      r_cli_err <= w_cli_err_nxt;
      r_cli_dat <= w_cli_dat_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_last    <= w_last_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_gcnt    <= w_gcnt_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign bus.adc_req    = r_adc_req;
  assign bus.busy       = r_busy;
  assign bus.cli_rdy    = r_cli_rdy;
  assign bus.cli_err    = r_cli_err;
  assign bus.cli_dat    = r_cli_dat;
  assign bus.gnt_id     = r_gnt_id;
  assign bus.err_sticky = r_err;

endmodule

// File: tb/tb_adc_share_arbiter.sv
// Directed bench for adc_share_arbiter with NREQ=4, DW=8, TIMEOUT=64, GAP=2.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: the bench plays both the clients and the ADC.
module tb_adc_share_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   n, h, g, seen;

  adc_share_arbiter_if #(.NREQ(4), .DW(8)) ifc ();

  adc_share_arbiter #(.NREQ(4), .DW(8), .TIMEOUT(64), .GAP(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (ifc.busy === 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(ifc.busy), 0);
  endtask

  initial begin
    rst         = 1'b1;
    ifc.en      = 1'b0;
    ifc.cli_req = 4'h0;
    ifc.adc_rdy = 1'b0;
    ifc.adc_dat = 8'h00;
    ifc.clr_err = 1'b0;
    #2;
    chk("rst_adc_req", 32'(ifc.adc_req), 0);
    chk("rst_busy",    32'(ifc.busy), 0);
    chk("rst_cli_rdy", 32'(ifc.cli_rdy), 0);
    chk("rst_cli_err", 32'(ifc.cli_err), 0);
    chk("rst_cli_dat", 32'(ifc.cli_dat), 0);
    chk("rst_gnt_id",  32'(ifc.gnt_id), 0);
    chk("rst_err",     32'(ifc.err_sticky), 0);
    tick();
    tick();
    rst = 1'b0;

    // Fairness: all four requesting, ADC answers one cycle after adc_req.
    ifc.en      = 1'b1;
    ifc.cli_req = 4'hF;
    g = 0;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (ifc.adc_req !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      if (k == 0) chk("fair_first_lat", n, 1);
      else        chk("fair_low_gap", n, 3);
      chk("fair_gnt", 32'(ifc.gnt_id), g);
      ifc.adc_rdy = 1'b1;
      ifc.adc_dat = 8'(16 + k);
      tick();
      ifc.adc_rdy = 1'b0;
      chk("fair_rdy", 32'(ifc.cli_rdy), 1 << g);
      chk("fair_err", 32'(ifc.cli_err), 0);
      chk("fair_dat", 32'(ifc.cli_dat), 16 + k);
      g = (g + 1) % 4;
    end
    ifc.cli_req = 4'h0;
    wait_idle("fair_idle");

    // Single client 2, ADC answers 3 cycles after adc_req with A5.
    ifc.cli_req = 4'b0100;
    tick();
    chk("one_gnt", 32'(ifc.gnt_id), 2);
    chk("one_adc_req", 32'(ifc.adc_req), 1);
    chk("one_busy", 32'(ifc.busy), 1);
    tick();
    tick();
    chk("one_hold", 32'(ifc.adc_req), 1);
    ifc.adc_rdy = 1'b1;
    ifc.adc_dat = 8'hA5;
    tick();
    ifc.adc_rdy = 1'b0;
    ifc.cli_req = 4'h0;
    chk("one_rdy", 32'(ifc.cli_rdy), 4);
    chk("one_dat", 32'(ifc.cli_dat), 'hA5);
    chk("one_req_low", 32'(ifc.adc_req), 0);
    tick();
    chk("one_rdy_pulse", 32'(ifc.cli_rdy), 0);
    chk("one_gap_busy", 32'(ifc.busy), 1);
    tick();
    chk("one_busy_drop", 32'(ifc.busy), 0);
    chk("one_gap_req", 32'(ifc.adc_req), 0);

    // Timeout: client 1, ADC silent.
    ifc.cli_req = 4'b0010;
    tick();
    chk("to_gnt", 32'(ifc.gnt_id), 1);
    h = (ifc.adc_req === 1'b1) ? 1 : 0;
    n = 0;
    while (ifc.adc_req === 1'b1 && n < 100) begin
      tick();
      n++;
      if (ifc.adc_req === 1'b1) h++;
    end
    chk("to_high_cycles", h, 64);
    chk("to_cli_err", 32'(ifc.cli_err), 2);
    chk("to_cli_rdy", 32'(ifc.cli_rdy), 0);
    chk("to_sticky", 32'(ifc.err_sticky), 1);
    chk("to_dat_kept", 32'(ifc.cli_dat), 'hA5);
    ifc.cli_req = 4'h0;
    tick();
    chk("to_err_pulse", 32'(ifc.cli_err), 0);
    chk("to_sticky_hold", 32'(ifc.err_sticky), 1);
    wait_idle("to_idle");
    ifc.clr_err = 1'b1;
    tick();
    ifc.clr_err = 1'b0;
    chk("to_clr", 32'(ifc.err_sticky), 0);

    // adc_rdy on the timeout edge: data wins.
    ifc.cli_req = 4'b0001;
    tick();
    chk("race_gnt", 32'(ifc.gnt_id), 0);
    repeat (63) tick();
    chk("race_still_req", 32'(ifc.adc_req), 1);
    chk("race_no_early_err", 32'(ifc.cli_err), 0);
    ifc.adc_rdy = 1'b1;
    ifc.adc_dat = 8'h5A;
    tick();
    ifc.adc_rdy = 1'b0;
    ifc.cli_req = 4'h0;
    chk("race_rdy", 32'(ifc.cli_rdy), 1);
    chk("race_err", 32'(ifc.cli_err), 0);
    chk("race_sticky", 32'(ifc.err_sticky), 0);
    chk("race_dat", 32'(ifc.cli_dat), 'h5A);
    wait_idle("race_idle");

    // en low blocks grants; dropping en mid-conversion lets it finish.
    ifc.en      = 1'b0;
    ifc.cli_req = 4'hF;
    seen = 0;
    repeat (6) begin
      tick();
      if (ifc.adc_req !== 1'b0) seen++;
    end
    chk("en0_no_req", seen, 0);
    ifc.en = 1'b1;
    tick();
    chk("en1_req", 32'(ifc.adc_req), 1);
    chk("en1_gnt", 32'(ifc.gnt_id), 1);
    ifc.en = 1'b0;
    tick();
    tick();
    ifc.adc_rdy = 1'b1;
    ifc.adc_dat = 8'h77;
    tick();
    ifc.adc_rdy = 1'b0;
    chk("endrop_rdy", 32'(ifc.cli_rdy), 2);
    chk("endrop_dat", 32'(ifc.cli_dat), 'h77);
    seen = 0;
    repeat (10) begin
      tick();
      if (ifc.adc_req !== 1'b0) seen++;
    end
    chk("endrop_no_regrant", seen, 0);
    chk("endrop_idle", 32'(ifc.busy), 0);

    // Reset two cycles into WAIT_ADC, then pointer restarts from reset.
    ifc.en = 1'b1;
    tick();
    chk("rstm_gnt", 32'(ifc.gnt_id), 2);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rstm_adc_req", 32'(ifc.adc_req), 0);
    chk("rstm_busy", 32'(ifc.busy), 0);
    chk("rstm_pulses", 32'({ifc.cli_rdy, ifc.cli_err}), 0);
    chk("rstm_gnt0", 32'(ifc.gnt_id), 0);
    ifc.cli_req = 4'b1000;
    tick();
    rst = 1'b0;
    tick();
    chk("rstm_regnt", 32'(ifc.gnt_id), 3);
    chk("rstm_req", 32'(ifc.adc_req), 1);
    ifc.adc_rdy = 1'b1;
    ifc.adc_dat = 8'hC3;
    tick();
    ifc.adc_rdy = 1'b0;
    ifc.cli_req = 4'h0;
    chk("rstm_rdy", 32'(ifc.cli_rdy), 8);
    chk("rstm_dat", 32'(ifc.cli_dat), 'hC3);
    wait_idle("rstm_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
